// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side and ALU-side handshake bundles of the ID/EX operand stage.
interface alu_operand_stage_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
);
    logic                  in_valid, in_ready;
    logic [3:0]            in_opt;
    logic [REG_ADDR_W-1:0] in_rs, in_rt, in_rd;
    logic [DATA_W-1:0]     in_rs_data, in_rt_data, in_imm;
    logic                  in_use_imm, in_wr_en, in_is_load;
    logic                  out_valid, out_ready;
    logic [3:0]            out_opt;
    logic [DATA_W-1:0]     out_a, out_b, out_rt_data;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_wr_en, out_is_load;

    modport master (
        output in_valid, in_opt, in_rs, in_rt, in_rd, in_rs_data, in_rt_data, in_imm,
               in_use_imm, in_wr_en, in_is_load, out_ready,
        input  in_ready, out_valid, out_opt, out_a, out_b, out_rt_data, out_rd, out_wr_en,
               out_is_load
    );

    modport slave (
        input  in_valid, in_opt, in_rs, in_rt, in_rd, in_rs_data, in_rt_data, in_imm,
               in_use_imm, in_wr_en, in_is_load, out_ready,
        output in_ready, out_valid, out_opt, out_a, out_b, out_rt_data, out_rd, out_wr_en,
               out_is_load
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ID/EX stage with operand forwarding and load-use hazard detection.
// ALU_OPERAND_FORWARDING_EN enables EX/MEM/WB forwarding; undefined, any pending writer of a source stalls.
module alu_operand_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    alu_operand_stage_if.slave    bus,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  hazard_stall,
    output logic [31:0]           stall_cycles
);
    logic                  valid_q, wr_en_q, is_load_q;
    logic [3:0]            opt_q;
    logic [DATA_W-1:0]     a_q, b_q, rt_data_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [31:0]           stall_q, stall_d;
    logic                  adv, hz, fire;
    logic [DATA_W-1:0]     rs_val, rt_val;

    // r0 is hardwired, so a write to index 0 never counts as a producer
    function automatic logic hit(input logic en, input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] s);
        return en && s != '0 && rd == s;
    endfunction

`ifdef ALU_OPERAND_FORWARDING_EN
    logic ex_fw, ex_ld;
    always_comb begin
        ex_fw  = valid_q && wr_en_q && !is_load_q;
        ex_ld  = valid_q && wr_en_q && is_load_q;
        rs_val = hit(ex_fw, rd_q, bus.in_rs) ? ex_result
               : hit(mem_wr_en, mem_rd, bus.in_rs) ? mem_data
               : hit(wb_wr_en, wb_rd, bus.in_rs) ? wb_data
               : bus.in_rs == '0 ? '0 : bus.in_rs_data;
        rt_val = hit(ex_fw, rd_q, bus.in_rt) ? ex_result
               : hit(mem_wr_en, mem_rd, bus.in_rt) ? mem_data
               : hit(wb_wr_en, wb_rd, bus.in_rt) ? wb_data
               : bus.in_rt == '0 ? '0 : bus.in_rt_data;
        hz     = hit(ex_ld, rd_q, bus.in_rs) || hit(ex_ld, rd_q, bus.in_rt);
    end
`else
    logic ex_wr, unused_fwd;
    assign unused_fwd = ^{ex_result, mem_data, wb_data};
    always_comb begin
        ex_wr  = valid_q && wr_en_q;
        rs_val = bus.in_rs == '0 ? '0 : bus.in_rs_data;
        rt_val = bus.in_rt == '0 ? '0 : bus.in_rt_data;
        hz     = hit(ex_wr, rd_q, bus.in_rs) || hit(ex_wr, rd_q, bus.in_rt)
              || hit(mem_wr_en, mem_rd, bus.in_rs) || hit(mem_wr_en, mem_rd, bus.in_rt)
              || hit(wb_wr_en, wb_rd, bus.in_rs) || hit(wb_wr_en, wb_rd, bus.in_rt);
    end
`endif

    always_comb begin
        adv          = !valid_q || bus.out_ready;
        bus.in_ready = adv && !hz && !flush;
        fire         = bus.in_valid && bus.in_ready;
        hazard_stall = bus.in_valid && hz;
        stall_d      = stall_q + 32'(hazard_stall && stall_q != '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            opt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rt_data_q <= '0;
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            if (fire) begin
                valid_q   <= 1'b1;
                opt_q     <= bus.in_opt;
                a_q       <= rs_val;
                b_q       <= bus.in_use_imm ? bus.in_imm : rt_val;
                rt_data_q <= rt_val;
                rd_q      <= bus.in_rd;
                wr_en_q   <= bus.in_wr_en;
                is_load_q <= bus.in_is_load;
            end else if (adv || flush) begin
                valid_q   <= 1'b0;
            end
            stall_q <= stall_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_opt     = opt_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.out_rt_data = rt_data_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_wr_en   = wr_en_q;
    assign bus.out_is_load = is_load_q;
    assign stall_cycles    = stall_q;
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered ID/EX stage directly upstream of the ALU. It accepts one decoded instruction per cycle over a valid/ready handshake. It resolves both source operands by forwarding from the instruction currently in EX, the MEM stage and the WB stage. It detects load-use hazards and presents registered `opt`/`a`/`b` to the ALU, plus the side fields that the EX/MEM stage needs.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register index width.
- `DATA_W`, default 32: operand width. It must match the ALU width.

Ports:
- `clk`: in, 1. Single clock; rising edge.
- `reset`: in, 1. Asynchronous, active-high reset.
- `flush`: in, 1. Synchronous kill of the held entry and the incoming entry.
- `in_valid` / `in_ready`: in / out, 1 / 1. Handshake from decode.
- `in_opt`: in, 4. ALU operation code.
- `in_rs`, `in_rt`, `in_rd`: in, 5 each. Source and destination register indices.
- `in_rs_data`, `in_rt_data`: in, 32 each. Register-file read values.
- `in_imm`: in, 32. Extended immediate.
- `in_use_imm`: in, 1. When 1, operand b = `in_imm`.
- `in_wr_en`, `in_is_load`: in, 1 each. Instruction writes `rd`; instruction is a load.
- `ex_result`: in, 32. Combinational ALU `out` for the held entry.
- `mem_wr_en`, `mem_rd`, `mem_data`: in, 1/5/32. Final result of the MEM stage.
- `wb_wr_en`, `wb_rd`, `wb_data`: in, 1/5/32. Write-back port.
- `out_valid` / `out_ready`: out / in, 1 / 1. Handshake toward the ALU/EX-MEM stage.
- `out_opt`, `out_a`, `out_b`: out, 4/32/32. ALU inputs.
- `out_rt_data`: out, 32. Forwarded `rt` value (store data).
- `out_rd`, `out_wr_en`, `out_is_load`: out, 5/1/1. Carried fields.
- `hazard_stall`: out, 1. High in any cycle where `in_valid` is 1 but a hazard blocks acceptance.
- `stall_cycles`: out, 32. Saturating count of `hazard_stall` cycles.

## Operation
- The stage holds one entry (`out_*`).
- Advance condition: `adv = !out_valid || out_ready`.
- Acceptance: `in_ready = adv && !hz && !flush`. A transfer (fire) occurs when `in_valid && in_ready`.
- On each edge:
  - fire: load the resolved entry and set `out_valid`=1.
  - else if `adv`: `out_valid`=0.
  - else: hold.
- Forwarding is evaluated per source `s` (`rs`, `rt`). The first match wins:
  1. EX: `out_valid && out_wr_en && !out_is_load && out_rd==s` → `ex_result`.
  2. MEM: `mem_wr_en && mem_rd==s` → `mem_data`.
  3. WB: `wb_wr_en && wb_rd==s` → `wb_data`.
  4. No match → register-file data.
- Index 0 never matches; r0 always resolves to 0.
- Load-use hazard `hz`: `out_valid && out_is_load && out_wr_en && out_rd!=0` and `out_rd` equals either `in_rs` or `in_rt`.
- Operand mapping:
  - `out_a` = resolved rs.
  - `out_b` = `in_use_imm ? in_imm : resolved rt`.
  - `out_rt_data` = resolved rt, regardless of `in_use_imm`.
- `flush`: at the next edge `out_valid`=0 and no fire occurs. Flush dominates a simultaneous `in_valid`.
- `stall_cycles` increments when `hazard_stall` is 1 and saturates at 0xFFFFFFFF.

## Timing
- Latency is one cycle from fire to `out_valid`. Throughput is 1 per cycle when there is no hazard and `out_ready` is held at 1.
- A load-use hazard inserts exactly one bubble when `out_ready`=1. The load leaves, `out_valid` drops for one cycle, and the dependent instruction then fires and takes `mem_data`.
- `out_*` fields hold stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_valid`, `out_ready`, `flush` and the hazard compare. It has no dependence on `in_valid`.
- Reset values: all `out_*` = 0, `out_valid`=0, `stall_cycles`=0. `in_ready` and `hazard_stall` follow from those values.
- An asserted `reset` mid-transfer discards the entry immediately. The first fire is allowed on the first edge after deassertion.

## Configuration
- `ALU_OPERAND_FORWARDING_EN` defined: forwarding and the single load-use hazard rule apply as described above.
- `ALU_OPERAND_FORWARDING_EN` undefined:
  - No forwarding; operands come only from the register file.
  - `hz` becomes true for any nonzero source matching a writing entry in EX (held and valid), MEM or WB.
  - The instruction waits until no stage matches. The register file is write-first on the edge after WB.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with `out_valid`=1 → `out_valid`=0, `out_a`=0 and `stall_cycles`=0 immediately.
- **Back-to-back ALU forward:** `add r3,r1,r2` (r1=5, r2=7), then `add r4,r3,r3` with `ex_result`=12 → second entry has `out_a`=`out_b`=12 and no stall.
- **Forwarding priority:** the same rs matches both MEM (`mem_data`=0x11) and WB (`wb_data`=0x22) → `out_a`=0x11. With rs=0 and all stages writing r0 → `out_a`=0.
- **Load-use:** a load to r8 is held, the next instruction reads r8, and `out_ready`=1 → `in_ready`=0 for 1 cycle, `hazard_stall`=1, one bubble, then fire with `out_a`=`mem_data`=0xDEAD. `stall_cycles`=1.
- **Backpressure and flush:** `out_ready`=0 for 3 cycles → `out_*` stable and `in_ready`=0. Then `flush` with `in_valid`=1 → `out_valid`=0 next cycle and the incoming entry is dropped.
- **Macro off:** a dependent pair r3 → r3 → stalls until the producer leaves WB, with `stall_cycles` incrementing to 3, then `out_a` equals `in_rs_data`.
